// File: rtl/paddsb_seq_ctrl_if.sv
// Requester handshake and result bus for the shared-adder PADDSB sequencer.
// The controller connects through the slave modport and requesters through master.
interface paddsb_seq_ctrl_if;
    logic        r0_valid;
    logic [15:0] r0_a;
    logic [15:0] r0_b;
    logic        r0_ready;
    logic        r1_valid;
    logic [15:0] r1_a;
    logic [15:0] r1_b;
    logic        r1_ready;
    logic        res_valid;
    logic        res_id;
    logic [15:0] res_s;
    logic [3:0]  res_sat;
    logic        busy;

    modport slave (
        input  r0_valid, r0_a, r0_b, r1_valid, r1_a, r1_b,
        output r0_ready, r1_ready, res_valid, res_id, res_s, res_sat, busy
    );

    modport master (
        output r0_valid, r0_a, r0_b, r1_valid, r1_a, r1_b,
        input  r0_ready, r1_ready, res_valid, res_id, res_s, res_sat, busy
    );
endinterface

// File: rtl/paddsb_seq_ctrl.sv
// Two-requester round-robin controller for a packed saturating nibble add,
// reusing one 4-bit signed lane adder over four cycles, LSB lane first.
module paddsb_seq_ctrl #(
    parameter bit SAT_EN = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    paddsb_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LANE = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        ptr_q, ptr_d;
    logic        id_q, id_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [15:0] work_q, work_d;
    logic [3:0]  flg_q, flg_d;
    logic [15:0] res_s_q, res_s_d;
    logic [3:0]  res_sat_q, res_sat_d;
    logic        res_id_q, res_id_d;

    logic        grant0, grant1;
    logic signed [3:0] lane_a, lane_b;
    logic [4:0]  lane_out;

    // Returns {overflow, lane result}; overflow is reported even when wrapping.
    function automatic logic [4:0] lane_add(input logic signed [3:0] a,
                                            input logic signed [3:0] b);
        logic signed [3:0] sum;
        logic              ovf;
        logic [3:0]        r;
        sum = a + b;
        ovf = (a[3] == b[3]) && (sum[3] != a[3]);
        r   = sum;
        if (SAT_EN && ovf) begin
            r = a[3] ? 4'b1000 : 4'b0111;
        end
        return {ovf, r};
    endfunction

    // Pointed requester wins when valid, otherwise the other one.
    assign grant0 = bus.r0_valid & (~ptr_q | ~bus.r1_valid);
    assign grant1 = bus.r1_valid & ( ptr_q | ~bus.r0_valid);

    assign bus.r0_ready  = rst_n & (state_q == IDLE) & grant0;
    assign bus.r1_ready  = rst_n & (state_q == IDLE) & grant1;
    assign bus.res_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.res_s     = res_s_q;
    assign bus.res_sat   = res_sat_q;
    assign bus.res_id    = res_id_q;

    assign lane_a   = a_q[{cnt_q, 2'b00} +: 4];
    assign lane_b   = b_q[{cnt_q, 2'b00} +: 4];
    assign lane_out = lane_add(lane_a, lane_b);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        work_d    = work_q;
        flg_d     = flg_q;
        res_s_d   = res_s_q;
        res_sat_d = res_sat_q;
        res_id_d  = res_id_q;
        case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    a_d     = grant1 ? bus.r1_a : bus.r0_a;
                    b_d     = grant1 ? bus.r1_b : bus.r0_b;
                    id_d    = grant1;
                    ptr_d   = ~grant1;
                    work_d  = 16'h0000;
                    flg_d   = 4'b0000;
                    cnt_d   = 2'd0;
                    state_d = LANE;
                end
            end
            LANE: begin
                work_d[{cnt_q, 2'b00} +: 4] = lane_out[3:0];
                flg_d[cnt_q]                = lane_out[4];
                cnt_d                       = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    res_s_d   = work_d;
                    res_sat_d = flg_d;
                    res_id_d  = id_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            ptr_q     <= 1'b0;
            res_s_q   <= 16'h0000;
            res_sat_q <= 4'b0000;
            res_id_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            res_s_q   <= res_s_d;
            res_sat_q <= res_sat_d;
            res_id_q  <= res_id_d;
        end
    end

    // Operand and working registers carry no reset; they are loaded on every accept.
    always_ff @(posedge clk) begin
        id_q   <= id_d;
        a_q    <= a_d;
        b_q    <= b_d;
        work_q <= work_d;
        flg_q  <= flg_d;
    end

endmodule

// File: doc/paddsb_seq_ctrl.md
Name: paddsb_seq_ctrl

Overview:
- Two-requester controller that shares one 4-bit signed saturating lane adder to perform the packed saturating nibble add (PADDSB) over 16-bit operands.
- Arbitrates round-robin between two requesters, latches the winner's operands, and sequences the four nibble lanes LSB-first, one lane per cycle.
- Returns the packed result with per-lane overflow flags.
- Sits beside the execute stage as a low-area alternative to four parallel lane adders.

Parameters:
SAT_EN, 1, 1 = clamp overflowing lanes to +7/-8; 0 = wrapping 4-bit add (overflow flags still reported)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
r0_valid  input  1  requester 0 has an operation pending
r0_a  input  16  requester 0 operand A (four signed 4-bit lanes)
r0_b  input  16  requester 0 operand B
r0_ready  output  1  requester 0 accepted this cycle
r1_valid  input  1  requester 1 has an operation pending
r1_a  input  16  requester 1 operand A
r1_b  input  16  requester 1 operand B
r1_ready  output  1  requester 1 accepted this cycle
res_valid  output  1  one-cycle pulse: res_s/res_id/res_sat are new
res_id  output  1  requester that owns the result
res_s  output  16  packed result, lane k = bits [4k+3:4k]
res_sat  output  4  bit k set if lane k overflowed
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset, sampled at the clk edge when rst_n=0:
  - state=IDLE, lane counter=0, priority pointer=r0.
  - res_valid=0, res_id=0, res_s=0x0000, res_sat=0000, busy=0.
  - Any in-flight operation is discarded with no result pulse.
  - r0_ready/r1_ready are 0 while rst_n=0.
- States:
  - IDLE: arbitration open.
  - LANE: lane counter 0..3.
  - DONE: result pulse.
- IDLE:
  - If any valid, grant by pointer: the pointed requester wins if its valid is set, else the other.
  - rX_ready is combinational, = (state==IDLE) & grantX; at most one ready per cycle.
  - On accept: latch A, B and id; clear the working result and flags; pointer := the non-granted requester; go to LANE with counter=0.
  - If neither valid: stay in IDLE, pointer unchanged.
- LANE:
  - Each cycle, the shared adder computes lane k = counter.
  - sum = a_k + b_k (4-bit).
  - ovf = (a_k[3]==b_k[3]) & (sum[3]!=a_k[3]).
  - If SAT_EN and ovf: lane result = 0111 when a_k[3]=0, 1000 when a_k[3]=1; otherwise lane result = sum.
  - Write the lane result into working bits [4k+3:4k] and ovf into flag bit k.
  - After k=3, go to DONE.
- DONE:
  - res_valid=1 for exactly this cycle; res_s, res_sat and res_id update to the working values at entry to DONE.
  - Next state is IDLE.
- Result outputs hold their last values until the next DONE or reset.
- Latency and throughput:
  - Accept at edge E.
  - LANE cycles E+1..E+4.
  - res_valid high in cycle E+5.
  - Next accept no earlier than cycle E+6 (one operation per 6 cycles).
- Requester rules:
  - A requester holds valid, a and b stable until it sees ready.
  - Operands changing after accept have no effect on the result.
  - A valid that rises while busy is served at the next IDLE cycle.
- No result backpressure: the consumer must take the result in the res_valid cycle.

Test Plan:
- Basic add: r0 only, A=0x1234, B=0x1111 -> r0_ready at accept; res_valid exactly 5 cycles later with res_s=0x2345, res_sat=0000, res_id=0; busy high for 5 cycles.
- Saturation: r1 only, A=0x7381, B=0x2F9F, SAT_EN=1 -> res_s=0x7280, res_sat=1010, res_id=1. Lane 3 clamps 7+2 to 7; lane 1 clamps -8+-7 to -8.
- Wrapping mode: SAT_EN=0, A=0x7381, B=0x2F9F -> res_s=0x9210, res_sat=1010.
- Round-robin fairness: both valid held continuously from reset with distinct operands -> grants in order r0, r1, r0, r1; res_id alternates; never two readies in one cycle; each result matches its requester's operands.
- Reset mid-operation: rst_n=0 for one edge during the LANE k=2 cycle -> next cycle busy=0, res_s=0x0000, res_sat=0000, no res_valid pulse. A following r1 request (A=0x0001, B=0x0001), with pointer at r0 and r0 idle, completes as res_s=0x0002, res_id=1.
- Late request: r1_valid rises while busy with r0, operands changed after r0's accept -> r1 accepted in the first IDLE cycle; r0 result unaffected.
